pixel_merge_unit: RTL and testbench
===================================

// Module: pixel_merge_unit
// PURPOSE
// Generalised N-core pixel collector between the RayProcessor cores and the video output stream.
// Core k renders raster pixels k, k+A, k+2A, ... of each frame, where A = number of active cores.
// The block buffers each core's pixels in its own FIFO and re-interleaves them into strict raster order.
// It emits one AXI-stream-style pixel stream carrying SOF and EOL, and backpressures each core independently.
// PARAMETERS
// NUM_CORES   4    number of core input lanes (1..8)
// FIFO_DEPTH  8    entries per core FIFO (power of 2, >=2)
// DIM_W       13   width of image_width / image_height and the x/y counters
// PORTS
// clk           in   1              clock, all logic rising-edge
// reset         in   1              synchronous, active-high
// active_cores  in   4              cores in use; sampled at frame start
// image_width   in   DIM_W          pixels per line; sampled at frame start
// image_height  in   DIM_W          lines per frame; sampled at frame start
// core_valid    in   NUM_CORES      per-core pixel valid
// core_pixel    in   NUM_CORES*24   per-core {r[7:0],g[7:0],b[7:0]}; lane k at [24k+:24]
// core_ready    out  NUM_CORES      per-core accept (compute_ready)
// out_ready     in   1              downstream ready
// out_valid     out  1              output pixel valid
// out_red       out  8              output red
// out_green     out  8              output green
// out_blue      out  8              output blue
// SOF_out       out  1              first pixel of frame (x==0,y==0), qualified by out_valid
// EOL_out       out  1              last pixel of line (x==W-1), qualified by out_valid
// BEHAVIOUR
// - Reset: all FIFOs empty; cur=0; x=y=0; out_valid=0; core_ready=0; SOF_out=EOL_out=0; A/W/H reloaded on the first cycle after reset.
// - Frame parameters: A=clamp(active_cores,1,NUM_CORES); W=max(image_width,1); H=max(image_height,1).
//   Latched in the first cycle after reset and after each completed frame; held constant mid-frame.
// - Input lanes: core_ready[k] = (k<A) && FIFO k not full, using the registered count.
//   A push happens iff core_valid[k]&&core_ready[k]; the pixel enters FIFO k at that clock edge.
//   core_valid on a lane with k>=A is ignored: no push, no error.
// - Output: out_valid = FIFO[cur] not empty; out_red/green/blue = head of FIFO[cur]. Output is combinational from registered FIFO state.
//   Latency: a pixel pushed at edge t is presentable from cycle t+1.
//   Data and flags hold stable while out_valid && !out_ready.
// - Transfer on out_valid&&out_ready: pop FIFO[cur]; cur <= (cur==A-1) ? 0 : cur+1.
//   x <= (x==W-1) ? 0 : x+1; y increments when x wraps.
// - End of frame is a transfer with x==W-1 && y==H-1:
//   x,y,cur <= 0; A/W/H re-latched for the next frame.
//   Pixels already queued in any FIFO are kept and belong to the next frame.
// - Push and pop on the same FIFO in the same cycle: both occur, count unchanged. A pop from a full FIFO frees the slot next cycle (ready is registered).
// - Other FIFOs non-empty while FIFO[cur] is empty: out_valid=0. Strict order; never skip a lane.
// - No deadlock: the output never waits on a FIFO other than cur, so a full non-cur FIFO cannot block it.
// - Reset asserted mid-frame: all queued pixels are discarded; the next output is SOF of a new frame.
// TESTING
// 1. A=2,W=4,H=2; both cores always valid, out_ready=1.
//    -> 8 pixels alternate core0/core1; SOF on pixel 0; EOL on pixels 3 and 7; cur back to 0 after pixel 7.
// 2. A=4, core2 stalled (valid=0) for 20 cycles.
//    -> output stops after pixel 1; FIFOs 0,1,3 fill to 8 and their ready drops; resumes in order after core2 resumes.
// 3. out_ready=0 for 10 cycles with all FIFOs full.
//    -> out_valid=1 and data held stable; core_ready=0; no pixel lost or duplicated when ready returns.
// 4. active_cores=0, then 9 with NUM_CORES=4.
//    -> behaves as A=1 (only lane 0 ready), then as A=4.
// 5. Change active_cores 2->3 mid-frame.
//    -> the current frame completes with A=2; the next SOF pixel comes from core0 and the frame uses A=3.
// 6. Assert reset for 1 cycle after 5 pixels of a W=8 frame.
//    -> out_valid=0 during reset; all FIFOs empty; the next transfer has SOF_out=1.

Source files
------------

// File: rtl/pixel_merge_unit.sv
// Collects per-core pixel lanes into per-core FIFOs and re-interleaves them into one raster-ordered
// pixel stream with SOF/EOL flags. Core k owns raster pixels k, k+A, k+2A, ... of every frame.
module pixel_merge_unit #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIM_W      = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              active_cores,
    input  logic [DIM_W-1:0]        image_width,
    input  logic [DIM_W-1:0]        image_height,
    input  logic [NUM_CORES-1:0]    core_valid,
    input  logic [NUM_CORES*24-1:0] core_pixel,
    output logic [NUM_CORES-1:0]    core_ready,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [7:0]              out_red,
    output logic [7:0]              out_green,
    output logic [7:0]              out_blue,
    output logic                    SOF_out,
    output logic                    EOL_out
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int LW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [23:0]      mem_q [NUM_CORES][FIFO_DEPTH];
    logic [23:0]      mem_d [NUM_CORES][FIFO_DEPTH];
    logic [PW-1:0]    wr_q [NUM_CORES];
    logic [PW-1:0]    wr_d [NUM_CORES];
    logic [PW-1:0]    rd_q [NUM_CORES];
    logic [PW-1:0]    rd_d [NUM_CORES];
    logic [CW-1:0]    cnt_q [NUM_CORES];
    logic [CW-1:0]    cnt_d [NUM_CORES];
    logic [LW-1:0]    cur_q, cur_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic [3:0]       a_q, a_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic             load_q, load_d;

    logic [3:0]       a_in, a_eff;
    logic [DIM_W-1:0] w_in, h_in, w_eff, h_eff;
    logic [23:0]      head;
    logic             xfer, eol, eof, push, pop;

    always_comb begin
        a_in = active_cores;
        if (active_cores == 4'd0)
            a_in = 4'd1;
        else if (active_cores > 4'(NUM_CORES))
            a_in = 4'(NUM_CORES);
        w_in = (image_width == '0) ? DIM_W'(1) : image_width;
        h_in = (image_height == '0) ? DIM_W'(1) : image_height;

        // Right after reset the frame parameters are taken straight from the inputs for this cycle.
        a_eff = load_q ? a_in : a_q;
        w_eff = load_q ? w_in : w_q;
        h_eff = load_q ? h_in : h_q;

        for (int unsigned k = 0; k < NUM_CORES; k++)
            core_ready[k] = !reset && (4'(k) < a_eff) && (cnt_q[k] != CW'(FIFO_DEPTH));

        head      = mem_q[cur_q][rd_q[cur_q]];
        out_valid = !reset && (cnt_q[cur_q] != '0);
        out_red   = head[23:16];
        out_green = head[15:8];
        out_blue  = head[7:0];
        eol       = (x_q == w_eff - DIM_W'(1));
        SOF_out   = out_valid && (x_q == '0) && (y_q == '0);
        EOL_out   = out_valid && eol;
        xfer      = out_valid && out_ready;
        eof       = xfer && eol && (y_q == h_eff - DIM_W'(1));
    end

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        push   = 1'b0;
        pop    = 1'b0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            push = core_valid[k] && core_ready[k];
            pop  = xfer && (cur_q == LW'(k));
            if (push) begin
                mem_d[k][wr_q[k]] = core_pixel[24*k +: 24];
                wr_d[k]           = PW'(wr_q[k] + 1'b1);
            end
            if (pop)
                rd_d[k] = PW'(rd_q[k] + 1'b1);
            if (push && !pop)
                cnt_d[k] = CW'(cnt_q[k] + 1'b1);
            else if (pop && !push)
                cnt_d[k] = CW'(cnt_q[k] - 1'b1);
        end

        cur_d  = cur_q;
        x_d    = x_q;
        y_d    = y_q;
        a_d    = a_eff;
        w_d    = w_eff;
        h_d    = h_eff;
        load_d = 1'b0;
        if (xfer) begin
            cur_d = (4'(cur_q) == a_eff - 4'd1) ? '0 : LW'(cur_q + 1'b1);
            if (eol) begin
                x_d = '0;
                y_d = DIM_W'(y_q + 1'b1);
            end else begin
                x_d = DIM_W'(x_q + 1'b1);
            end
        end
        if (eof) begin
            cur_d = '0;
            x_d   = '0;
            y_d   = '0;
            a_d   = a_in;
            w_d   = w_in;
            h_d   = h_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '{default: '0};
            rd_q   <= '{default: '0};
            cnt_q  <= '{default: '0};
            cur_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            a_q    <= 4'd1;
            w_q    <= DIM_W'(1);
            h_q    <= DIM_W'(1);
            load_q <= 1'b1;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            x_q    <= x_d;
            y_q    <= y_d;
            a_q    <= a_d;
            w_q    <= w_d;
            h_q    <= h_d;
            load_q <= load_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pixel_merge_unit.sv
// Randomised bench for pixel_merge_unit: a queue-per-core reference model predicts ready, the
// output pixel and its SOF/EOL flags from the raster index of the next pixel in the frame.
module tb_pixel_merge_unit;
    localparam int NC    = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      active_cores;
    logic [DW-1:0]   image_width, image_height;
    logic [NC-1:0]   core_valid;
    logic [NC*24-1:0] core_pixel;
    logic [NC-1:0]   core_ready;
    logic            out_ready, out_valid, SOF_out, EOL_out;
    logic [7:0]      out_red, out_green, out_blue;

    int n_checks = 0;
    int n_errors = 0;

    pixel_merge_unit #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .DIM_W(DW)) dut (
        .clk(clk), .reset(reset), .active_cores(active_cores),
        .image_width(image_width), .image_height(image_height),
        .core_valid(core_valid), .core_pixel(core_pixel), .core_ready(core_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_red(out_red),
        .out_green(out_green), .out_blue(out_blue), .SOF_out(SOF_out), .EOL_out(EOL_out)
    );

    always #5 clk = ~clk;

    // Observed and predicted outputs packed as {core_ready, valid, rgb (0 when idle), SOF, EOL}
    logic [30:0] act, expv;
    assign act = {core_ready, out_valid, out_valid ? {out_red, out_green, out_blue} : 24'h0,
                  SOF_out, EOL_out};

    logic [23:0] mq[NC][$];
    int m_a, m_w, m_h, m_p;
    bit m_load;
    int e_a, e_w, e_h, e_cur;
    bit e_valid;
    logic [NC-1:0] e_ready;

    function automatic int clamp_a(input logic [3:0] v);
        if (v == 0) return 1;
        if (int'(v) > NC) return NC;
        return int'(v);
    endfunction

    function automatic int atleast1(input logic [DW-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    task automatic predict();
        logic [23:0] d;
        int x;
        if (reset) begin
            expv    = '0;
            e_valid = 1'b0;
            e_ready = '0;
        end else begin
            e_a   = m_load ? clamp_a(active_cores) : m_a;
            e_w   = m_load ? atleast1(image_width) : m_w;
            e_h   = m_load ? atleast1(image_height) : m_h;
            e_cur = m_p % e_a;
            x     = m_p % e_w;
            for (int k = 0; k < NC; k++)
                e_ready[k] = (k < e_a) && (mq[k].size() < DEPTH);
            e_valid = mq[e_cur].size() != 0;
            d       = e_valid ? mq[e_cur][0] : 24'h0;
            expv    = {e_ready, e_valid, d, e_valid && m_p == 0, e_valid && x == e_w - 1};
        end
    endtask

    task automatic advance();
        logic [23:0] dummy;
        if (reset) begin
            for (int k = 0; k < NC; k++) mq[k].delete();
            m_p    = 0;
            m_load = 1'b1;
        end else begin
            if (m_load) begin
                m_a = e_a; m_w = e_w; m_h = e_h; m_load = 1'b0;
            end
            if (e_valid && out_ready) begin
                dummy = mq[e_cur].pop_front();
                m_p++;
                if (m_p == m_w * m_h) begin
                    m_p = 0;
                    m_a = clamp_a(active_cores);
                    m_w = atleast1(image_width);
                    m_h = atleast1(image_height);
                end
            end
            for (int k = 0; k < NC; k++)
                if (core_valid[k] && e_ready[k]) mq[k].push_back(core_pixel[24*k +: 24]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_pixels();
        core_pixel = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            #1; predict(); advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        core_valid = '1; out_ready = 1'b1; active_cores = 4'd4;
        image_width = 13'd4; image_height = 13'd2;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            new_pixels(); #1; predict();
            n_checks++;
            if (out_valid !== 1'b0 || core_ready !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs: got valid=%b ready=%b, expected valid=0 ready=0",
                         out_valid, core_ready);
            end
            advance();
        end
        reset = 1'b0;
        new_pixels(); #1; predict();
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected %h", act, expv);
        end
        advance();
    endtask

    task automatic test_two_cores();
        active_cores = 4'd2; image_width = 13'd4; image_height = 13'd2;
        core_valid = 4'b1111; out_ready = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 24; i++) begin
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL two_cores cyc%0d: got %h expected %h", i, act, expv);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        active_cores = 4'd4; image_width = 13'd16; image_height = 13'd4;
        out_ready = 1'b1;
        apply_reset(1);
        for (int i = 0; i < 60; i++) begin
            core_valid = (i < 20) ? 4'b1011 : 4'b1111;
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL stall cyc%0d: got %h expected %h", i, act, expv);
            end
            advance();
        end
    endtask

    task automatic test_back_pressure();
        logic [23:0] held;
        active_cores = 4'd4; image_width = 13'd16; image_height = 13'd8;
        core_valid = 4'b1111; out_ready = 1'b0;
        apply_reset(1);
        for (int i = 0; i < 60; i++) begin
            out_ready = (i >= 22);
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL back_pressure cyc%0d: got %h expected %h", i, act, expv);
            end
            if (i == 12) held = {out_red, out_green, out_blue};
            if (i == 21) begin
                n_checks++;
                if ({out_red, out_green, out_blue} !== held || core_ready !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL back_pressure_hold: got rgb=%h ready=%b expected rgb=%h ready=0000",
                             {out_red, out_green, out_blue}, core_ready, held);
                end
            end
            advance();
        end
    endtask

    task automatic test_clamp();
        active_cores = 4'd0; image_width = 13'd3; image_height = 13'd2;
        core_valid = 4'b1111; out_ready = 1'b1;
        apply_reset(1);
        for (int i = 0; i < 50; i++) begin
            if (i == 3) active_cores = 4'd9;
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL clamp cyc%0d: got %h expected %h", i, act, expv);
            end
            advance();
        end
    endtask

    task automatic test_mid_frame_change();
        active_cores = 4'd2; image_width = 13'd5; image_height = 13'd3;
        core_valid = 4'b1111; out_ready = 1'b1;
        apply_reset(1);
        for (int i = 0; i < 50; i++) begin
            if (i == 6) active_cores = 4'd3;
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL mid_frame_change cyc%0d: got %h expected %h", i, act, expv);
            end
            advance();
        end
    endtask

    task automatic test_mid_frame_reset();
        active_cores = 4'd4; image_width = 13'd8; image_height = 13'd2;
        core_valid = 4'b1111; out_ready = 1'b1;
        apply_reset(1);
        for (int i = 0; i < 30; i++) begin
            reset = (i == 6);
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL mid_frame_reset cyc%0d: got %h expected %h", i, act, expv);
            end
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        apply_reset(1);
        for (int i = 0; i < 3000; i++) begin
            active_cores = 4'($urandom_range(0, 9));
            image_width  = DW'($urandom_range(0, 6));
            image_height = DW'($urandom_range(0, 3));
            core_valid   = NC'($urandom());
            out_ready    = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 499) == 0);
            new_pixels(); #1; predict();
            n_checks++;
            if (act !== expv) begin
                n_errors++;
                $display("FAIL random cyc%0d: got %h expected %h", i, act, expv);
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; core_valid = '0; core_pixel = '0; out_ready = 1'b0;
        active_cores = 4'd1; image_width = 13'd1; image_height = 13'd1;
        m_a = 1; m_w = 1; m_h = 1; m_p = 0; m_load = 1'b1;
        #1;
        test_reset();
        test_two_cores();
        test_stall();
        test_back_pressure();
        test_clamp();
        test_mid_frame_change();
        test_mid_frame_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
